// File: rtl/partition_sweep_pkg.sv
// Shared types and constants for the partition sweep controller.
package partition_sweep_pkg;

  localparam int unsigned DEF_IN_W   = 7;
  localparam int unsigned DEF_OUT_W  = 4;
  localparam int unsigned DEF_SETTLE = 1;

  // popcount helper operates on a fixed-width word; callers zero-extend into it
  localparam int unsigned PC_IN_W  = 32;
  localparam int unsigned PC_OUT_W = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SAMPLE = 3'd2,
    OFFER  = 3'd3,
    DONE   = 3'd4
  } sweep_state_t;

  // Number of set bits in v.
  function automatic logic [PC_OUT_W-1:0] popcount(input logic [PC_IN_W-1:0] v);
    logic [PC_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(PC_IN_W); i++) begin
      n = n + PC_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/partition_sweep_ctrl_err_acc.sv
// Error statistics for the partition sweep: counts mismatching vectors and
// accumulates the Hamming distance between po and ref_po.
// Only compiled when SWEEP_ERR_STATS_EN is defined.
`ifdef SWEEP_ERR_STATS_EN
module sweep_err_acc
  import partition_sweep_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               en,
  input  logic [OUT_W-1:0]                   po,
  input  logic [OUT_W-1:0]                   ref_po,
  output logic [IN_W:0]                      err_count,
  output logic [IN_W+$clog2(OUT_W+1)-1:0]    ham_sum
);

  localparam int unsigned ERR_W = IN_W + 1;
  localparam int unsigned HAM_W = IN_W + $clog2(OUT_W + 1);

  logic [OUT_W-1:0] diff;
  logic [HAM_W-1:0] diff_bits;

  assign diff      = po ^ ref_po;
  assign diff_bits = HAM_W'(popcount(PC_IN_W'(diff)));

  // Clear on sweep start, accumulate once per sampled vector.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_count <= '0;
      ham_sum   <= '0;
    end else if (en) begin
      if (|diff) begin
        err_count <= err_count + ERR_W'(1);
      end
      ham_sum <= ham_sum + diff_bits;
    end
  end

endmodule
`endif

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive input sweep controller for a combinational partition: drives every
// vector 0..2^IN_W-1 onto pi, samples po after SETTLE cycles and offers each
// result as a valid/ready beat. Error statistics against ref_po are built only
// when SWEEP_ERR_STATS_EN is defined; otherwise err_count/ham_sum read as 0.
module partition_sweep_ctrl
  import partition_sweep_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned SETTLE = DEF_SETTLE
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  output logic [IN_W-1:0]                    pi,
  input  logic [OUT_W-1:0]                   po,
  input  logic [OUT_W-1:0]                   ref_po,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [IN_W-1:0]                    out_idx,
  output logic [OUT_W-1:0]                   out_po,
  output logic                               busy,
  output logic                               done,
  output logic [IN_W:0]                      err_count,
  output logic [IN_W+$clog2(OUT_W+1)-1:0]    ham_sum
);

  localparam int unsigned CNT_W = 4;
  localparam logic [IN_W-1:0] IDX_LAST = '1;

  sweep_state_t     state, state_nxt;
  logic [IN_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sample;
  logic             stats_clr;
  logic             stats_en;

  // Next-state and control decode; abort wins over any handshake.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    sample    = 1'b0;
    stats_clr = 1'b0;
    stats_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = APPLY;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          stats_clr = 1'b1;
        end
      end
      APPLY: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(SETTLE - 1)) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          sample    = 1'b1;
          stats_en  = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_ready) begin
          if (idx == IDX_LAST) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + IN_W'(1);
            cnt_nxt   = '0;
            state_nxt = APPLY;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, index and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      out_po    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      if (sample) begin
        out_po <= po;
      end
      out_valid <= (state_nxt == OFFER);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

  // The index register drives the partition and labels the beat directly.
  assign pi      = idx;
  assign out_idx = idx;

`ifdef SWEEP_ERR_STATS_EN
  sweep_err_acc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_err_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (stats_clr),
    .en        (stats_en),
    .po        (po),
    .ref_po    (ref_po),
    .err_count (err_count),
    .ham_sum   (ham_sum)
  );
`else
  assign err_count = '0;
  assign ham_sum   = '0;

  logic unused_stats;
  assign unused_stats = ^{ref_po, stats_clr, stats_en};
`endif

endmodule
